// File: rtl/l2_tlb_sa.sv
// l2_tlb_sa: set-associative second-level TLB.
// One-cycle lookup with registered response, single-cycle fill with
// hit-way / invalid-way / round-robin replacement, and a set-walking flush
// (full or ASID-selective) during which the block reports busy.
// Optional build macro: L2_TLB_PERF_CNT_EN adds saturating hit/miss counters.
module l2_tlb_sa #(
  parameter int ENTRIES = 128,
  parameter int ASSOC   = 4,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44,
  parameter int ASID_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  output logic              lookup_ready_o,
  input  logic [VPN_W-1:0]  lookup_vpn_i,
  input  logic [ASID_W-1:0] lookup_asid_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [PPN_W-1:0]  resp_ppn_o,
  output logic [7:0]        resp_perm_o,
  input  logic              fill_valid_i,
  output logic              fill_ready_o,
  input  logic [VPN_W-1:0]  fill_vpn_i,
  input  logic [ASID_W-1:0] fill_asid_i,
  input  logic [PPN_W-1:0]  fill_ppn_i,
  input  logic [7:0]        fill_perm_i,
  input  logic              flush_i,
  input  logic              flush_asid_en_i,
  input  logic [ASID_W-1:0] flush_asid_i,
`ifdef L2_TLB_PERF_CNT_EN
  output logic              busy_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`else
  output logic              busy_o
`endif
);

  localparam int SETS  = ENTRIES / ASSOC;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int G_BIT = 5;  // perm byte is {D,A,G,U,X,W,R,V}

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   flush_idx_q;
  logic               flush_asid_en_q;
  logic [ASID_W-1:0]  flush_asid_q;

  logic [ASSOC-1:0]   valid_q  [SETS];
  logic [WAY_W-1:0]   rr_q     [SETS];
  logic [TAG_W-1:0]   tag_mem  [SETS][ASSOC];
  logic [ASID_W-1:0]  asid_mem [SETS][ASSOC];
  logic [PPN_W-1:0]   ppn_mem  [SETS][ASSOC];
  logic [7:0]         perm_mem [SETS][ASSOC];

  logic               flush_go, lookup_go, fill_go;
  logic [IDX_W-1:0]   lk_set, fl_set;
  logic [TAG_W-1:0]   lk_tag, fl_tag;
  logic               lk_hit, fl_hit, fl_free, fill_replace;
  logic [WAY_W-1:0]   lk_way, fl_hit_way, fl_free_way, fill_way, rr_next;
  logic [ASSOC-1:0]   flush_kill;

  assign busy_o         = (state_q == ST_FLUSH);
  assign lookup_ready_o = ~busy_o;
  assign fill_ready_o   = ~busy_o;

  assign flush_go  = flush_i && (state_q == ST_IDLE);
  assign lookup_go = lookup_valid_i && lookup_ready_o;
  // A flush in the same cycle wins over a fill; the fill is dropped.
  assign fill_go   = fill_valid_i && fill_ready_o && !flush_go;

  assign lk_set = lookup_vpn_i[IDX_W-1:0];
  assign lk_tag = lookup_vpn_i[VPN_W-1:IDX_W];
  assign fl_set = fill_vpn_i[IDX_W-1:0];
  assign fl_tag = fill_vpn_i[VPN_W-1:IDX_W];

  // Lookup tag match against current (pre-write) contents, lowest way wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!lk_hit && valid_q[lk_set][w] && (tag_mem[lk_set][w] == lk_tag) &&
          (perm_mem[lk_set][w][G_BIT] || (asid_mem[lk_set][w] == lookup_asid_i))) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // Fill victim choice: existing matching way, else lowest invalid, else round-robin.
  always_comb begin
    fl_hit      = 1'b0;
    fl_hit_way  = '0;
    fl_free     = 1'b0;
    fl_free_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!fl_hit && valid_q[fl_set][w] && (tag_mem[fl_set][w] == fl_tag) &&
          (perm_mem[fl_set][w][G_BIT] || (asid_mem[fl_set][w] == fill_asid_i))) begin
        fl_hit     = 1'b1;
        fl_hit_way = WAY_W'(w);
      end
      if (!fl_free && !valid_q[fl_set][w]) begin
        fl_free     = 1'b1;
        fl_free_way = WAY_W'(w);
      end
    end
    fill_replace = !fl_hit && !fl_free;
    fill_way     = fl_hit ? fl_hit_way : (fl_free ? fl_free_way : rr_q[fl_set]);
    rr_next      = (rr_q[fl_set] == WAY_W'(ASSOC - 1)) ? '0 : rr_q[fl_set] + WAY_W'(1);
  end

  // Ways of the set under the flush cursor that this flush removes.
  always_comb begin
    flush_kill = '0;
    for (int w = 0; w < ASSOC; w++) begin
      flush_kill[w] = !flush_asid_en_q ||
                      (!perm_mem[flush_idx_q][w][G_BIT] && (asid_mem[flush_idx_q][w] == flush_asid_q));
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: one flush walk of SETS cycles, then back to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (flush_go) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_idx_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Valid bits, round-robin pointers and flush cursor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      flush_idx_q     <= '0;
      flush_asid_en_q <= 1'b0;
      flush_asid_q    <= '0;
    end else begin
      if (flush_go) begin
        flush_asid_en_q <= flush_asid_en_i;
        flush_asid_q    <= flush_asid_i;
      end
      if (state_q == ST_FLUSH) begin
        valid_q[flush_idx_q] <= valid_q[flush_idx_q] & ~flush_kill;
        flush_idx_q          <= flush_idx_q + IDX_W'(1);
      end
      if (fill_go) begin
        valid_q[fl_set][fill_way] <= 1'b1;
        if (fill_replace) rr_q[fl_set] <= rr_next;
      end
    end
  end

  // Entry payload storage, written on accepted fills.
  always_ff @(posedge clk_i) begin
    // NOTE: payload arrays carry no reset; the valid bits alone decide whether an entry counts.
    if (fill_go) begin
      tag_mem[fl_set][fill_way]  <= fl_tag;
      asid_mem[fl_set][fill_way] <= fill_asid_i;
      ppn_mem[fl_set][fill_way]  <= fill_ppn_i;
      perm_mem[fl_set][fill_way] <= fill_perm_i;
    end
  end

  // Registered lookup response; payload forced to zero on a miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_ppn_o   <= '0;
      resp_perm_o  <= '0;
    end else begin
      resp_valid_o <= lookup_go;
      resp_hit_o   <= lookup_go && lk_hit;
      resp_ppn_o   <= (lookup_go && lk_hit) ? ppn_mem[lk_set][lk_way]  : '0;
      resp_perm_o  <= (lookup_go && lk_hit) ? perm_mem[lk_set][lk_way] : '0;
    end
  end

`ifdef L2_TLB_PERF_CNT_EN
  // Saturating hit/miss counters, updated alongside each response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lookup_go) begin
      if (lk_hit) begin
        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_l2_tlb_sa.sv
// tb_l2_tlb_sa: table-driven checks of l2_tlb_sa with a response scoreboard,
// plus hand-written flush / reset sequences.
module tb_l2_tlb_sa;
  localparam int VPN_W  = 27;
  localparam int PPN_W  = 44;
  localparam int ASID_W = 16;
  localparam int SETS   = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              lookup_valid_i, lookup_ready_o;
  logic [VPN_W-1:0]  lookup_vpn_i;
  logic [ASID_W-1:0] lookup_asid_i;
  logic              resp_valid_o, resp_hit_o;
  logic [PPN_W-1:0]  resp_ppn_o;
  logic [7:0]        resp_perm_o;
  logic              fill_valid_i, fill_ready_o;
  logic [VPN_W-1:0]  fill_vpn_i;
  logic [ASID_W-1:0] fill_asid_i;
  logic [PPN_W-1:0]  fill_ppn_i;
  logic [7:0]        fill_perm_i;
  logic              flush_i, flush_asid_en_i;
  logic [ASID_W-1:0] flush_asid_i;
  logic              busy_o;
`ifdef L2_TLB_PERF_CNT_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  l2_tlb_sa dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_vpn_i(lookup_vpn_i), .lookup_asid_i(lookup_asid_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
    .resp_ppn_o(resp_ppn_o), .resp_perm_o(resp_perm_o),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
    .fill_vpn_i(fill_vpn_i), .fill_asid_i(fill_asid_i),
    .fill_ppn_i(fill_ppn_i), .fill_perm_i(fill_perm_i),
    .flush_i(flush_i), .flush_asid_en_i(flush_asid_en_i), .flush_asid_i(flush_asid_i),
`ifdef L2_TLB_PERF_CNT_EN
    .busy_o(busy_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`else
    .busy_o(busy_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic              lk;
    logic              fl;
    logic [VPN_W-1:0]  lvpn;
    logic [ASID_W-1:0] lasid;
    logic [VPN_W-1:0]  fvpn;
    logic [ASID_W-1:0] fasid;
    logic [PPN_W-1:0]  ppn;
    logic [7:0]        perm;
    logic              ehit;
    logic [PPN_W-1:0]  eppn;
    logic [7:0]        eperm;
  } vec_t;

  vec_t        tbl[$];
  logic [52:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t vf(input int vpn, input int asid, input logic [PPN_W-1:0] ppn, input logic [7:0] perm);
    vec_t v = '0;
    v.fl = 1'b1; v.fvpn = VPN_W'(vpn); v.fasid = ASID_W'(asid); v.ppn = ppn; v.perm = perm;
    return v;
  endfunction

  function automatic vec_t vl(input int vpn, input int asid, input logic hit, input logic [PPN_W-1:0] eppn, input logic [7:0] eperm);
    vec_t v = '0;
    v.lk = 1'b1; v.lvpn = VPN_W'(vpn); v.lasid = ASID_W'(asid);
    v.ehit = hit; v.eppn = eppn; v.eperm = eperm;
    return v;
  endfunction

  function automatic vec_t vb(input vec_t f, input vec_t l);
    vec_t v = l;
    v.fl = 1'b1; v.fvpn = f.fvpn; v.fasid = f.fasid; v.ppn = f.ppn; v.perm = f.perm;
    return v;
  endfunction

  // Drive one cycle of stimulus; a lookup pushes its expected response.
  task automatic apply(input vec_t v);
    @(posedge clk_i); #1;
    lookup_valid_i = v.lk; lookup_vpn_i = v.lvpn; lookup_asid_i = v.lasid;
    fill_valid_i = v.fl; fill_vpn_i = v.fvpn; fill_asid_i = v.fasid;
    fill_ppn_i = v.ppn; fill_perm_i = v.perm;
    if (v.lk) exp_q.push_back({v.ehit, v.eppn, v.eperm});
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0; fill_valid_i = 1'b0;
    flush_i = 1'b0; flush_asid_en_i = 1'b0; flush_asid_i = '0;
  endtask

  task automatic drain(input string name);
    idle();
    repeat (3) @(posedge clk_i);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
    drain(name);
  endtask

  // Pulse flush_i together with the given vector; returns one cycle after acceptance.
  task automatic do_flush(input logic en, input int asid, input vec_t v);
    apply(v);
    flush_i = 1'b1; flush_asid_en_i = en; flush_asid_i = ASID_W'(asid);
    idle();
  endtask

  task automatic wait_flush(output int busy_cyc, output int ready_low);
    busy_cyc = 0; ready_low = 0;
    while (busy_o && busy_cyc < 200) begin
      if (!lookup_ready_o && !fill_ready_o) ready_low++;
      busy_cyc++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i && resp_valid_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: got resp_valid_o=1 expected 0");
      end else begin
        check("resp", {resp_hit_o, resp_ppn_o, resp_perm_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, rl;
    rst_i = 1'b1;
    lookup_valid_i = 0; lookup_vpn_i = '0; lookup_asid_i = '0;
    fill_valid_i = 0; fill_vpn_i = '0; fill_asid_i = '0; fill_ppn_i = '0; fill_perm_i = '0;
    flush_i = 0; flush_asid_en_i = 0; flush_asid_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("reset_outputs",
          {resp_valid_o, resp_hit_o, resp_ppn_o, resp_perm_o, busy_o, lookup_ready_o, fill_ready_o},
          {1'b0, 1'b0, 44'h0, 8'h00, 1'b0, 1'b1, 1'b1});

    // Basic hit/miss, set-0 replacement, global entries, overwrite and same-cycle read.
    tbl.push_back(vf(32'h10, 3, 44'hABC, 8'h0F));
    tbl.push_back(vl(32'h10, 3, 1'b1, 44'hABC, 8'h0F));
    tbl.push_back(vl(32'h10, 4, 1'b0, 44'h0, 8'h00));
    for (int i = 0; i < 5; i++) tbl.push_back(vf(i * 32, 1, 44'h100 + 44'(i), 8'h0F));
    tbl.push_back(vl(32'h00, 1, 1'b0, 44'h0, 8'h00));
    for (int i = 1; i < 5; i++) tbl.push_back(vl(i * 32, 1, 1'b1, 44'h100 + 44'(i), 8'h0F));
    tbl.push_back(vf(32'h05, 7, 44'h55, 8'h2F));
    tbl.push_back(vl(32'h05, 9, 1'b1, 44'h55, 8'h2F));
    tbl.push_back(vl(32'h25, 7, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vf(32'h20, 1, 44'h999, 8'h0F));
    tbl.push_back(vl(32'h20, 1, 1'b1, 44'h999, 8'h0F));
    tbl.push_back(vf(32'hA0, 1, 44'h105, 8'h0F));
    tbl.push_back(vl(32'h20, 1, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'hA0, 1, 1'b1, 44'h105, 8'h0F));
    tbl.push_back(vl(32'h40, 1, 1'b1, 44'h102, 8'h0F));
    tbl.push_back(vl(32'h80, 1, 1'b1, 44'h104, 8'h0F));
    tbl.push_back(vb(vf(32'h10, 3, 44'h123, 8'h0F), vl(32'h10, 3, 1'b1, 44'hABC, 8'h0F)));
    tbl.push_back(vl(32'h10, 3, 1'b1, 44'h123, 8'h0F));
    tbl.push_back(vf(32'h01, 3, 44'h11, 8'h0F));
    tbl.push_back(vf(32'h02, 3, 44'h22, 8'h2F));
    tbl.push_back(vf(32'h03, 5, 44'h33, 8'h0F));
    run_tbl("drain_basic");

    // ASID-selective flush of ASID 3.
    do_flush(1'b1, 3, '0);
    wait_flush(bc, rl);
    check("asid_flush_busy_cycles", bc, SETS);
    check("asid_flush_ready_low", rl, SETS);
    tbl.push_back(vl(32'h01, 3, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'h02, 3, 1'b1, 44'h22, 8'h2F));
    tbl.push_back(vl(32'h03, 5, 1'b1, 44'h33, 8'h0F));
    tbl.push_back(vl(32'h10, 3, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'h40, 1, 1'b1, 44'h102, 8'h0F));
    run_tbl("drain_asid_flush");

    // Fill in the flush cycle is dropped; the lookup in that cycle sees old contents.
    do_flush(1'b1, 9, vb(vf(32'h03, 2, 44'h99, 8'h0F), vl(32'h03, 5, 1'b1, 44'h33, 8'h0F)));
    wait_flush(bc, rl);
    check("fill_flush_busy_cycles", bc, SETS);
    check("fill_flush_ready_low", rl, SETS);
    tbl.push_back(vl(32'h03, 2, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'h03, 5, 1'b1, 44'h33, 8'h0F));
    run_tbl("drain_fill_flush");

    // Reset in the middle of a flush that would not have removed anything.
    do_flush(1'b1, 9, '0);
    repeat (9) @(posedge clk_i);
    #1;
    check("busy_mid_flush", busy_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("busy_after_reset", {busy_o, lookup_ready_o, fill_ready_o}, 3'b011);
    tbl.push_back(vl(32'h02, 3, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'h03, 5, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'h40, 1, 1'b0, 44'h0, 8'h00));
    tbl.push_back(vl(32'h05, 7, 1'b0, 44'h0, 8'h00));
    run_tbl("drain_reset_flush");

`ifdef L2_TLB_PERF_CNT_EN
    do_reset();
    check("perf_cnt_reset", {hit_cnt_o, miss_cnt_o}, 64'h0);
    tbl.push_back(vf(32'h01, 1, 44'hAA, 8'h0F));
    for (int i = 0; i < 3; i++) tbl.push_back(vl(32'h01, 1, 1'b1, 44'hAA, 8'h0F));
    for (int i = 0; i < 2; i++) tbl.push_back(vl(32'h09, 1, 1'b0, 44'h0, 8'h00));
    run_tbl("drain_perf");
    check("hit_cnt", hit_cnt_o, 32'd3);
    check("miss_cnt", miss_cnt_o, 32'd2);
`else
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
